// File: rtl/tdc_shift_readout_ctrl.sv
// Frame sequencer for the dual-edge TDC capture chain: shifts NBITS sclk periods, settles, then offers the word on valid/ready.
// Optional start/stop marker check is built when TDC_FRAME_CHECK_EN is defined (adds frame_err output).
module tdc_shift_readout_ctrl #(
    parameter int NBITS      = 33,
    parameter int CLK_DIV    = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ack,
    output logic             busy,
    output logic             sclk,
    output logic             sen,
    input  logic [NBITS-1:0] chain_data,
    output logic [NBITS-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef TDC_FRAME_CHECK_EN
    output logic             frame_err,
`endif
    output logic [7:0]       drop_cnt
);

    localparam int RW = $clog2(NBITS + 1);
    localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [RW-1:0] RISE_LAST = RW'(NBITS);
    localparam logic [3:0]    SET_LAST  = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_div_cnt;
    logic [RW-1:0]    r_rise_cnt;
    logic [3:0]       r_settle_cnt;
    logic             r_sclk;
    logic             r_sen;
    logic             r_start_ack;
    logic             r_out_valid;
    logic [NBITS-1:0] r_out_data;
    logic [7:0]       r_drop_cnt;

    logic             w_accept;
    logic             w_div_tick;
    logic             w_toggle;
    logic             w_last_fall;
    logic             w_capture;
    logic             w_release;
    logic             w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_toggle    = 1'b0;
        w_last_fall = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_div_tick  = (r_div_cnt == DIV_LAST);
        w_drop      = start && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_div_tick) begin
                    w_toggle = 1'b1;
                    // The frame ends on the falling edge that follows the last counted rise.
                    if (r_sclk && (r_rise_cnt == RISE_LAST)) begin
                        w_last_fall = 1'b1;
                        w_state_nxt = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == SET_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_rise_cnt <= '0;
            r_sclk     <= 1'b0;
            r_sen      <= 1'b0;
        end else if (w_accept) begin
            r_div_cnt  <= '0;
            r_rise_cnt <= '0;
            r_sclk     <= 1'b0;
            r_sen      <= 1'b1;
        end else if (r_state == S_SHIFT) begin
            r_div_cnt <= w_div_tick ? 8'd0 : (r_div_cnt + 8'd1);
            if (w_toggle) begin
                r_sclk <= ~r_sclk;
                if (!r_sclk) begin
                    r_rise_cnt <= r_rise_cnt + RW'(1);
                end
            end
            if (w_last_fall) begin
                r_sen <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if (w_last_fall) begin
            r_settle_cnt <= '0;
        end else if ((r_state == S_SETTLE) && !w_capture) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_ack <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_start_ack <= w_accept;
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= chain_data;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Every busy cycle with start high counts, so a held request is charged repeatedly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

`ifdef TDC_FRAME_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (w_capture) begin
            r_frame_err <= !chain_data[NBITS-1] || chain_data[0];
        end else if (w_release) begin
            r_frame_err <= 1'b0;
        end
    end

    assign frame_err = r_frame_err;
`endif

    assign start_ack = r_start_ack;
    assign busy      = (r_state != S_IDLE);
    assign sclk      = r_sclk;
    assign sen       = r_sen;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/tdc_shift_readout_ctrl.md
Name: tdc_shift_readout_ctrl

Overview:
- Sequencer for the 33-bit dual-edge serial capture chain used in TDC readout test.
- Generates the chain's shift clock and enable, and counts exactly NBITS shift clocks per frame.
- After the chain settles, latches the 33-bit parallel word and offers it downstream on a valid/ready handshake.
- Sits between the readout trigger logic and the readout FIFO/serializer.

Parameters:
- NBITS, 33, bits per frame and width of the captured word.
- CLK_DIV, 2, system clocks per half period of sclk; legal range 1..255.
- SETTLE_CYC, 2, system clocks between the final sclk falling edge and the capture; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  frame request; sampled only in IDLE.
- start_ack  out  1  one-cycle pulse when a request is accepted.
- busy  out  1  high in every state except IDLE.
- sclk  out  1  shift clock to the chain; low whenever not shifting.
- sen  out  1  enable to the chain; high only in SHIFT.
- chain_data  in  NBITS  parallel output of the chain.
- out_data  out  NBITS  captured word; stable while out_valid is high.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- drop_cnt  out  8  count of rejected start requests; saturates at 255.

Behaviour:
- Reset: on rst high at a clk edge, state=IDLE.
  - Reset values: sclk=0, sen=0, start_ack=0, busy=0, out_valid=0, out_data=0, drop_cnt=0, all internal counters=0.
  - Reset mid-frame aborts the frame immediately. No word is produced. sclk drops to 0 on the next edge.
- States: IDLE, SHIFT, SETTLE, HOLD.
- IDLE:
  - If start=1 at edge T: next state SHIFT. start_ack=1 and sen=1 from T+1. start_ack lasts one cycle.
- SHIFT:
  - sclk starts low and toggles every CLK_DIV cycles. The first rising edge is at T+1+CLK_DIV.
  - Rising edges are counted. After the NBITS-th rising edge, sclk completes its high half period and falls.
  - On that falling edge: sen=0, next state SETTLE.
  - SHIFT lasts exactly 2*NBITS*CLK_DIV cycles.
- SETTLE:
  - Waits SETTLE_CYC cycles. On the last cycle, out_data is loaded from chain_data and the state moves to HOLD.
  - out_valid=1 on the first HOLD cycle.
  - Total latency from the accepting edge T to out_valid high = 1 + 2*NBITS*CLK_DIV + SETTLE_CYC (defaults: 135).
- HOLD:
  - out_valid=1, out_data held.
  - On an edge with out_ready=1: out_valid=0 next cycle, state returns to IDLE.
  - A start in that same cycle is not accepted; minimum gap between frames is one IDLE cycle.
  - out_ready while out_valid=0 has no effect.
- Rejected requests: start=1 in any state other than IDLE increments drop_cnt, saturating at 255.
  - Rising-edge detection is not used: each cycle start is high while busy counts once.
  - start held high in IDLE is accepted once per frame.
- Width: rising-edge counter is clog2(NBITS+1) bits; divider counter is 8 bits; no wrap is possible within legal parameters.
- sclk and sen are driven directly from flops (glitch-free).

Optional Feature:
- Macro: TDC_FRAME_CHECK_EN.
- With the macro: extra output frame_err (1 bit, reset 0).
  - At capture, frame_err is set if chain_data[NBITS-1] != 1 (missing start marker) or chain_data[0] != 0 (missing stop marker).
  - frame_err is valid alongside out_valid and cleared when the word is accepted.
  - out_data is captured unchanged in both cases.
- Without the macro: no frame_err port and no checking logic.

Test Plan:
1. Defaults, rst 3 cycles, then start pulse at cycle 10 -> start_ack at 11; 33 sclk rising edges, the first at 13; sen high cycles 11..142; out_valid at 145.
2. chain_data driven 33'h1_5A5A_A5A4, out_ready held 0 for 20 cycles then 1 -> out_data=33'h1_5A5A_A5A4 stable through HOLD; out_valid drops one cycle after ready; busy=0 after.
3. CLK_DIV=1, SETTLE_CYC=1, start held high continuously -> back-to-back frames each 1+66+1 cycles plus one HOLD and one IDLE cycle with ready=1; drop_cnt increments every busy cycle and saturates at 255.
4. rst asserted at cycle 40 of SHIFT -> next edge: sclk=0, sen=0, busy=0, no out_valid; next start produces a full 33-edge frame.
5. start asserted in the same cycle out_ready accepts the word -> not acknowledged, drop_cnt+1; start on the following IDLE cycle -> start_ack.
6. With TDC_FRAME_CHECK_EN: chain_data=33'h0_0000_0000 -> frame_err=1 with out_valid; chain_data=33'h1_0000_0000 -> frame_err=0.
